trig_window_ctrl: RTL and testbench

TRIG_WINDOW_CTRL -- requirements
Module: trig_window_ctrl

---
 rtl/trig_window_ctrl_pkg.sv | 15 +
 rtl/trig_window_ctrl_if.sv | 11 +
 rtl/trig_window_ctrl.sv | 118 +++++++++++
 tb/tb_trig_window_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_window_ctrl_pkg.sv
// Shared state encoding and trigger-source mode constants for the trigger window controller.
package trig_window_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WINDOW,
    ST_HOLDOFF
  } state_t;

  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_TICK = 2'd1;
  localparam logic [1:0] MODE_EXT  = 2'd2;
  localparam logic [1:0] MODE_SW   = 2'd3;

endpackage

// File: rtl/trig_window_ctrl_if.sv
// FIFO-side write bundle: per-channel write requests, full flags and readout permission.
interface trig_window_ctrl_if #(
  parameter int unsigned NCH = 2
);
  logic           ro_en;
  logic [NCH-1:0] fifo_full;
  logic [NCH-1:0] wr_en;

  modport master (input ro_en, input fifo_full, output wr_en);
  modport slave  (output ro_en, output fifo_full, input wr_en);
endinterface

// File: rtl/trig_window_ctrl.sv
// Trigger-driven capture window controller: IDLE -> WINDOW -> HOLDOFF with
// accepted/dropped trigger accounting and sticky per-channel truncation flags.
module trig_window_ctrl
  import trig_window_pkg::*;
#(
  parameter int unsigned NCH    = 2,
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              tick,
  input  logic              ext_trg,
  input  logic              sw_trg,
  input  logic [CNT_W-1:0]  win_len,
  input  logic [CNT_W-1:0]  holdoff,
  input  logic [NCH-1:0]    ch_mask,
  trig_window_ctrl_if.master fifo_if,
  output logic              busy,
  output logic              win_done,
  output logic [NCH-1:0]    trunc,
  output logic [31:0]       trig_cnt,
  output logic [DROP_W-1:0] drop_cnt
);

  state_t              r_state;
  state_t              w_next;
  logic                r_ext_q;
  logic [CNT_W-1:0]    r_win_cnt;
  logic [CNT_W-1:0]    r_hold_cnt;
  logic [NCH-1:0]      r_mask;
  logic                r_win_done;
  logic [NCH-1:0]      r_trunc;
  logic [31:0]         r_trig_cnt;
  logic [DROP_W-1:0]   r_drop_cnt;

  logic                w_ext_rise;
  logic                w_trg;
  logic                w_accept;
  logic                w_win_last;
  logic                w_hold_last;
  logic [NCH-1:0]      w_ch_open;

  assign w_ext_rise  = ext_trg & ~r_ext_q;
  assign w_trg       = en & (((mode == MODE_TICK) & tick) |
                             ((mode == MODE_EXT) & w_ext_rise) |
                             ((mode != MODE_OFF) & sw_trg));
  assign w_accept    = (r_state == ST_IDLE) & w_trg & (win_len != '0);
  assign w_win_last  = (r_state == ST_WINDOW) & (r_win_cnt == CNT_W'(1));
  assign w_hold_last = (r_state == ST_HOLDOFF) & (r_hold_cnt == CNT_W'(1));
  assign w_ch_open   = r_mask & {NCH{fifo_if.ro_en}};

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!en) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (w_accept) w_next = ST_WINDOW;
        ST_WINDOW:  if (w_win_last) w_next = (r_hold_cnt != '0) ? ST_HOLDOFF : ST_IDLE;
        ST_HOLDOFF: if (w_hold_last) w_next = ST_IDLE;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy          = (r_state != ST_IDLE);
    fifo_if.wr_en = '0;
    if (r_state == ST_WINDOW) fifo_if.wr_en = w_ch_open & ~fifo_if.fifo_full;
  end

  // The two down-counters double as the latched window length and holdoff;
  // each only counts while its own state is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext_q    <= 1'b1;
      r_win_cnt  <= '0;
      r_hold_cnt <= '0;
      r_mask     <= '0;
      r_win_done <= 1'b0;
      r_trunc    <= '0;
      r_trig_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_ext_q    <= ext_trg;
      r_win_done <= en & w_win_last;
      if (w_accept) begin
        r_win_cnt  <= win_len;
        r_hold_cnt <= holdoff;
        r_mask     <= ch_mask;
        r_trunc    <= '0;
        r_trig_cnt <= r_trig_cnt + 32'd1;
      end else begin
        if (r_state == ST_WINDOW) begin
          r_win_cnt <= r_win_cnt - CNT_W'(1);
          r_trunc   <= r_trunc | (w_ch_open & fifo_if.fifo_full);
        end
        if (r_state == ST_HOLDOFF) r_hold_cnt <= r_hold_cnt - CNT_W'(1);
      end
      if (w_trg && (r_state != ST_IDLE) && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
    end
  end

  assign win_done = r_win_done;
  assign trunc    = r_trunc;
  assign trig_cnt = r_trig_cnt;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_trig_window_ctrl.sv
// Directed bench for trig_window_ctrl: a per-cycle vector table plus multi-cycle scenarios.
module tb_trig_window_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic        tick;
  logic        ext_trg;
  logic        sw_trg;
  logic [11:0] win_len;
  logic [11:0] holdoff;
  logic [1:0]  ch_mask;
  logic        busy;
  logic        win_done;
  logic [1:0]  trunc;
  logic [31:0] trig_cnt;
  logic [1:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  trig_window_ctrl_if #(.NCH(2)) fif ();

  trig_window_ctrl #(.NCH(2), .CNT_W(12), .DROP_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .tick    (tick),
    .ext_trg (ext_trg),
    .sw_trg  (sw_trg),
    .win_len (win_len),
    .holdoff (holdoff),
    .ch_mask (ch_mask),
    .fifo_if (fif),
    .busy    (busy),
    .win_done(win_done),
    .trunc   (trunc),
    .trig_cnt(trig_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic        tick;
    logic        sw;
    logic [11:0] wl;
    logic [11:0] ho;
    logic [1:0]  mask;
    logic [1:0]  full;
    logic [1:0]  wr;
    logic        busy;
    logic        done;
    logic [1:0]  trunc;
    logic [31:0] tc;
    logic [1:0]  dc;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t v(input logic e, input logic [1:0] m, input logic t, input logic s,
                             input logic [11:0] wl, input logic [11:0] ho, input logic [1:0] mk,
                             input logic [1:0] fl, input logic [1:0] wr, input logic b,
                             input logic d, input logic [1:0] tr, input logic [31:0] tc,
                             input logic [1:0] dc);
    vec_t r;
    r.en = e; r.mode = m; r.tick = t; r.sw = s; r.wl = wl; r.ho = ho; r.mask = mk; r.full = fl;
    r.wr = wr; r.busy = b; r.done = d; r.trunc = tr; r.tc = tc; r.dc = dc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; mode = 2'd0; tick = 1'b0; ext_trg = 1'b0; sw_trg = 1'b0;
    win_len = '0; holdoff = '0; ch_mask = '0; fif.ro_en = 1'b1; fif.fifo_full = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int good;
    int dones;

    // table: 3-cycle windows, holdoff 2, drops, truncation, ignored requests
    tbl[0]  = v(1, 3, 0, 0, 3, 2, 3, 0,  0, 0, 0, 0, 0, 0);
    tbl[1]  = v(1, 3, 0, 1, 3, 2, 3, 0,  0, 0, 0, 0, 0, 0);
    tbl[2]  = v(1, 3, 0, 0, 3, 2, 3, 0,  3, 1, 0, 0, 1, 0);
    tbl[3]  = v(1, 3, 0, 1, 3, 2, 3, 0,  3, 1, 0, 0, 1, 0);
    tbl[4]  = v(1, 3, 0, 0, 3, 2, 3, 1,  2, 1, 0, 0, 1, 1);
    tbl[5]  = v(1, 3, 0, 0, 3, 2, 3, 0,  0, 1, 1, 1, 1, 1);
    tbl[6]  = v(1, 3, 0, 0, 3, 2, 3, 0,  0, 1, 0, 1, 1, 1);
    tbl[7]  = v(1, 3, 0, 1, 3, 2, 3, 0,  0, 0, 0, 1, 1, 1);
    tbl[8]  = v(1, 3, 0, 0, 0, 0, 1, 0,  3, 1, 0, 0, 2, 1);
    tbl[9]  = v(1, 3, 0, 0, 0, 0, 1, 0,  3, 1, 0, 0, 2, 1);
    tbl[10] = v(1, 3, 0, 0, 0, 0, 1, 0,  3, 1, 0, 0, 2, 1);
    tbl[11] = v(1, 3, 0, 0, 0, 0, 1, 0,  0, 1, 1, 0, 2, 1);
    tbl[12] = v(1, 3, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 2, 1);
    tbl[13] = v(1, 3, 0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 2, 1);
    tbl[14] = v(1, 0, 0, 1, 3, 2, 3, 0,  0, 0, 0, 0, 2, 1);
    tbl[15] = v(1, 1, 0, 0, 3, 2, 3, 0,  0, 0, 0, 0, 2, 1);
    tbl[16] = v(1, 2, 1, 0, 3, 2, 3, 0,  0, 0, 0, 0, 2, 1);
    tbl[17] = v(1, 2, 0, 0, 3, 2, 3, 0,  0, 0, 0, 0, 2, 1);
    tbl[18] = v(0, 3, 0, 1, 3, 2, 3, 0,  0, 0, 0, 0, 2, 1);
    tbl[19] = v(0, 3, 0, 0, 3, 2, 3, 0,  0, 0, 0, 0, 2, 1);

    do_reset();
    chk("rst_wr", {30'd0, fif.wr_en}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, win_done}, 0);
    chk("rst_trunc", {30'd0, trunc}, 0);
    chk("rst_trig", trig_cnt, 0);
    chk("rst_drop", {30'd0, drop_cnt}, 0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      en = tbl[i].en; mode = tbl[i].mode; tick = tbl[i].tick; sw_trg = tbl[i].sw;
      win_len = tbl[i].wl; holdoff = tbl[i].ho; ch_mask = tbl[i].mask; fif.fifo_full = tbl[i].full;
      #1;
      chk($sformatf("tbl%0d_wr", i), {30'd0, fif.wr_en}, {30'd0, tbl[i].wr});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
      chk($sformatf("tbl%0d_done", i), {31'd0, win_done}, {31'd0, tbl[i].done});
      chk($sformatf("tbl%0d_trunc", i), {30'd0, trunc}, {30'd0, tbl[i].trunc});
      chk($sformatf("tbl%0d_trig", i), trig_cnt, tbl[i].tc);
      chk($sformatf("tbl%0d_drop", i), {30'd0, drop_cnt}, {30'd0, tbl[i].dc});
    end

    // tick-triggered 1024-cycle window, no holdoff
    do_reset();
    @(negedge clk);
    en = 1; mode = 2'd1; win_len = 12'd1024; holdoff = 12'd0; ch_mask = 2'b11; tick = 1;
    good = 0;
    for (int k = 1; k <= 1024; k++) begin
      @(negedge clk);
      tick = 0;
      #1;
      if (fif.wr_en == 2'b11 && busy && !win_done) good++;
    end
    chk("long_win_cycles", good, 1024);
    @(negedge clk);
    #1;
    chk("long_done", {31'd0, win_done}, 1);
    chk("long_wr_off", {30'd0, fif.wr_en}, 0);
    chk("long_idle", {31'd0, busy}, 0);
    chk("long_trig", trig_cnt, 1);
    @(negedge clk);
    #1;
    chk("long_done_once", {31'd0, win_done}, 0);

    // external edges: second rise inside window is dropped, rise in first IDLE cycle accepted
    do_reset();
    en = 1; mode = 2'd2; win_len = 12'd4; holdoff = 12'd8; ch_mask = 2'b11;
    good = 0;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      ext_trg = (k == 0 || k == 3 || k == 13);
      #1;
      if (k >= 1 && k <= 12 && fif.wr_en == 2'b11) good++;
      if (k == 12) chk("ext_busy_last_hold", {31'd0, busy}, 1);
      if (k == 13) begin
        chk("ext_first_idle", {31'd0, busy}, 0);
        chk("ext_drop", {30'd0, drop_cnt}, 1);
        chk("ext_trig_one", trig_cnt, 1);
      end
      if (k == 14) begin
        chk("ext_trig_two", trig_cnt, 2);
        chk("ext_busy_again", {31'd0, busy}, 1);
      end
    end
    chk("ext_win_cycles", good, 4);
    ext_trg = 0;

    // full on channel 0 during window cycles 5..7
    do_reset();
    en = 1; mode = 2'd3; win_len = 12'd16; holdoff = 12'd0; ch_mask = 2'b01;
    good = 0;
    dones = 0;
    for (int k = 0; k <= 17; k++) begin
      logic [1:0] exp_wr;
      @(negedge clk);
      sw_trg = (k == 0);
      fif.fifo_full = (k >= 5 && k <= 7) ? 2'b01 : 2'b00;
      #1;
      exp_wr = (k >= 1 && k <= 16 && !(k >= 5 && k <= 7)) ? 2'b01 : 2'b00;
      if (fif.wr_en == exp_wr) good++;
      if (busy) dones++;
      if (k == 17) begin
        chk("full_done", {31'd0, win_done}, 1);
        chk("full_trunc", {30'd0, trunc}, 2'b01);
      end
    end
    chk("full_wr_pattern", good, 18);
    chk("full_win_len", dones, 16);

    // enable drop mid-window, then a zero-length request
    do_reset();
    en = 1; mode = 2'd3; win_len = 12'd100; holdoff = 12'd5; ch_mask = 2'b11;
    dones = 0;
    for (int k = 0; k <= 110; k++) begin
      @(negedge clk);
      sw_trg = (k == 0);
      if (k == 40) en = 0;
      #1;
      if (k == 40) chk("en_wr_still", {30'd0, fif.wr_en}, 2'b11);
      if (k == 41) begin
        chk("en_wr_off", {30'd0, fif.wr_en}, 0);
        chk("en_busy_off", {31'd0, busy}, 0);
      end
      if (win_done) dones++;
    end
    chk("en_no_done", dones, 0);
    @(negedge clk);
    en = 1; win_len = 12'd0; sw_trg = 1;
    @(negedge clk);
    sw_trg = 0;
    #1;
    chk("zero_len_trig", trig_cnt, 1);
    chk("zero_len_busy", {31'd0, busy}, 0);
    chk("zero_len_drop", {30'd0, drop_cnt}, 0);

    // drop counter saturation and coincident tick + sw in IDLE
    do_reset();
    en = 1; mode = 2'd1; win_len = 12'd50; holdoff = 12'd0; ch_mask = 2'b11;
    for (int k = 0; k <= 53; k++) begin
      @(negedge clk);
      tick   = (k == 0 || k == 52);
      sw_trg = (k == 5 || k == 10 || k == 15 || k == 20 || k == 25 || k == 52);
      #1;
      if (k == 51) chk("sat_drop", {30'd0, drop_cnt}, 3);
      if (k == 53) begin
        chk("coinc_trig", trig_cnt, 2);
        chk("coinc_drop", {30'd0, drop_cnt}, 3);
      end
    end
    tick = 0; sw_trg = 0;

    // reset mid-window with ext_trg held high across release
    do_reset();
    en = 1; mode = 2'd3; win_len = 12'd50; holdoff = 12'd0; ch_mask = 2'b11;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      sw_trg = (k == 0);
      if (k == 10) begin rst = 1; mode = 2'd2; ext_trg = 1; end
      if (k == 11) rst = 0;
      #1;
      if (k == 10) chk("rst_mid_wr_on", {30'd0, fif.wr_en}, 2'b11);
      if (k == 11) begin
        chk("rst_mid_wr", {30'd0, fif.wr_en}, 0);
        chk("rst_mid_busy", {31'd0, busy}, 0);
        chk("rst_mid_done", {31'd0, win_done}, 0);
        chk("rst_mid_trig", trig_cnt, 0);
      end
      if (k == 14) begin
        chk("ext_high_rel_busy", {31'd0, busy}, 0);
        chk("ext_high_rel_trig", trig_cnt, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
